// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default sizing,
// and the address-legality decode shared with the initiator side.
package dmem_responder_pkg;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_LATENCY   = 2;
  localparam int CNT_BITS      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A request is illegal if misaligned or if any bit above the word index is set.
  function automatic logic addr_err(input logic [31:0] addr, input int abits);
    logic err;
    err = (addr[1:0] != 2'b00);
    for (int i = 2; i < 32; i++) begin
      if ((i >= abits + 2) && addr[i]) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit storage with synchronous write and combinational read.
module dmem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the CPU data-memory interface: one request at a time,
// fixed service latency, registered response held until consumed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  logic                  req_err;
  logic [ADDR_BITS-1:0]  word_idx;

  assign word_idx = addr_q[ADDR_BITS+1:2];
  assign req_err  = addr_err(addr_q, ADDR_BITS);

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (wdata_q),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_BITS'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit point: the store lands or the load data is captured here.
          state_d = ST_RESP;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (write_q) begin
            ram_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = ram_rdata;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
